hazard_fwd_scoreboard: RTL and testbench

Parametrised hazard-resolution block for the 5-stage core. It tracks the source registers of the instruction moving from ID into EX and produces the per-source forwarding selects for the EX operand muxes. It detects load-use and multi-cycle-unit (MC) hazards and generates the ID stall and EX bubble, using a one-entry scoreboard for the MC unit. It replaces the purely combinational EX forwarding logic and adds NSRC sources, stall generation and MC tracking.

---
 rtl/hazard_fwd_scoreboard.sv | 156 +++++++++++++++
 tb/tb_hazard_fwd_scoreboard.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_scoreboard.sv
// Hazard resolution for the 5-stage core: EX operand forwarding, load-use and MC-unit stalls, one-entry MC scoreboard.
// Optional stall-cycle performance counter is built when HFS_PERF_CNT_EN is defined.
module hazard_fwd_scoreboard #(
    parameter int REG_AW = 5,
    parameter int NSRC   = 2,
    parameter int MC_LAT = 4   // issue-to-writeback cycles, >= 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [NSRC*REG_AW-1:0] id_src,
    input  logic [NSRC-1:0]        id_src_v,
    input  logic [REG_AW-1:0]      id_rd,
    input  logic                   id_is_mc,
    input  logic                   flush,
    input  logic [REG_AW-1:0]      ex_rd,
    input  logic                   ex_memread,
    input  logic [REG_AW-1:0]      mem_rd,
    input  logic                   mem_regwrite,
    input  logic [REG_AW-1:0]      wb_rd,
    input  logic                   wb_regwrite,
    output logic [2*NSRC-1:0]      fwd_sel,
    output logic                   stall,
    output logic                   ex_bubble,
    output logic                   mc_busy,
    output logic                   mc_done,
    output logic [15:0]            stall_cnt
);

    // state   | meaning
    // RUN     | no MC op outstanding, scoreboard entry free
    // MC_WAIT | MC op in flight, mc_rd_q holds its destination, mc_cnt counts down

    localparam int CW = $clog2(MC_LAT + 1);

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CW-1:0]          mc_cnt;
    logic [REG_AW-1:0]      mc_rd_q;
    logic [NSRC*REG_AW-1:0] ex_src;
    logic [NSRC-1:0]        ex_src_v;
    logic                   ex_bubble_q;
    logic                   lu_hit;
    logic                   mc_src_hit;
    logic                   lu;
    logic                   mch;
    logic                   issue;

    // hazard detection on the instruction sitting in ID
    always_comb begin
        lu_hit     = 1'b0;
        mc_src_hit = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (id_src_v[i] && (id_src[i*REG_AW +: REG_AW] == ex_rd))
                lu_hit = 1'b1;
            if (id_src_v[i] && (id_src[i*REG_AW +: REG_AW] == mc_rd_q))
                mc_src_hit = 1'b1;
        end
    end

    assign lu    = id_valid & ex_memread & (ex_rd != '0) & lu_hit;
    assign mch   = (state == MC_WAIT) & id_valid &
                   ((mc_src_hit & (mc_rd_q != '0)) | id_is_mc);
    assign stall = (lu | mch) & ~flush;
    assign issue = id_valid & id_is_mc & ~stall & ~flush;

    // forwarding selects from the registered EX sources; EX/MEM wins over MEM/WB
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (ex_src_v[i] && mem_regwrite && (mem_rd != '0) &&
                (mem_rd == ex_src[i*REG_AW +: REG_AW]))
                fwd_sel[2*i +: 2] = 2'b10;
            else if (ex_src_v[i] && wb_regwrite && (wb_rd != '0) &&
                     (wb_rd == ex_src[i*REG_AW +: REG_AW]))
                fwd_sel[2*i +: 2] = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_src      <= '0;
            ex_src_v    <= '0;
            ex_bubble_q <= 1'b1;
        end else if (flush || stall) begin
            ex_src_v    <= '0;
            ex_bubble_q <= 1'b1;
        end else begin
            ex_src      <= id_src;
            ex_src_v    <= id_src_v & {NSRC{id_valid}};
            ex_bubble_q <= ~id_valid;
        end
    end

    assign ex_bubble = ex_bubble_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mc_busy   = 1'b0;
        mc_done   = 1'b0;
        case (state)
            RUN: begin
                if (issue)
                    state_nxt = MC_WAIT;
            end
            MC_WAIT: begin
                mc_busy = 1'b1;
                mc_done = (mc_cnt == CW'(1));
                if (mc_done)
                    state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // mc_rd_q is left stale after the op retires; mch only looks at it in MC_WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_cnt  <= '0;
            mc_rd_q <= '0;
        end else if ((state == RUN) && issue) begin
            mc_cnt  <= CW'(MC_LAT);
            mc_rd_q <= id_rd;
        end else if (state == MC_WAIT) begin
            mc_cnt  <= mc_cnt - CW'(1);
        end
    end

`ifdef HFS_PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_q <= '0;
        else if (stall && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// Bench for hazard_fwd_scoreboard (REG_AW=5, NSRC=2, MC_LAT=4): vector table with an
// expectation queue, plus hand sequences for load-use, MC scoreboard, flush and reset.
module tb_hazard_fwd_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [9:0]  id_src;
    logic [1:0]  id_src_v;
    logic [4:0]  id_rd;
    logic        id_is_mc;
    logic        flush;
    logic [4:0]  ex_rd;
    logic        ex_memread;
    logic [4:0]  mem_rd;
    logic        mem_regwrite;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic        ex_bubble;
    logic        mc_busy;
    logic        mc_done;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    hazard_fwd_scoreboard #(.REG_AW(5), .NSRC(2), .MC_LAT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_src       (id_src),
        .id_src_v     (id_src_v),
        .id_rd        (id_rd),
        .id_is_mc     (id_is_mc),
        .flush        (flush),
        .ex_rd        (ex_rd),
        .ex_memread   (ex_memread),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd_sel      (fwd_sel),
        .stall        (stall),
        .ex_bubble    (ex_bubble),
        .mc_busy      (mc_busy),
        .mc_done      (mc_done),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       id_valid;
        logic [9:0] id_src;
        logic [1:0] id_src_v;
        logic       flush;
        logic [4:0] ex_rd;
        logic       ex_memread;
        logic [4:0] mem_rd;
        logic       mem_regwrite;
        logic [4:0] wb_rd;
        logic       wb_regwrite;
        logic       exp_stall;
        logic [3:0] exp_fwd;
        logic       exp_bubble;
    } vec_t;

    typedef struct packed {
        logic [3:0] fwd;
        logic       bubble;
    } exp_t;

    localparam int NV = 13;
    vec_t vt [NV];
    exp_t exq [$];

    function automatic vec_t mk(input logic v, input logic [4:0] s1, input logic [4:0] s0,
                                input logic [1:0] sv, input logic fl,
                                input logic [4:0] erd, input logic emr,
                                input logic [4:0] mrd, input logic mwr,
                                input logic [4:0] wrd, input logic wwr,
                                input logic est, input logic [3:0] efwd, input logic ebub);
        vec_t r;
        r.id_valid     = v;
        r.id_src       = {s1, s0};
        r.id_src_v     = sv;
        r.flush        = fl;
        r.ex_rd        = erd;
        r.ex_memread   = emr;
        r.mem_rd       = mrd;
        r.mem_regwrite = mwr;
        r.wb_rd        = wrd;
        r.wb_regwrite  = wwr;
        r.exp_stall    = est;
        r.exp_fwd      = efwd;
        r.exp_bubble   = ebub;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        id_valid     = 1'b0;
        id_src       = '0;
        id_src_v     = '0;
        id_rd        = '0;
        id_is_mc     = 1'b0;
        flush        = 1'b0;
        ex_rd        = '0;
        ex_memread   = 1'b0;
        mem_rd       = '0;
        mem_regwrite = 1'b0;
        wb_rd        = '0;
        wb_regwrite  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue_mc(input logic [4:0] rd);
        id_valid = 1'b1;
        id_is_mc = 1'b1;
        id_rd    = rd;
        id_src   = '0;
        id_src_v = '0;
    endtask

    initial begin
        exp_t e;
        int   nst;
        logic seen;

        rst_n = 1'b0;
        idle();
        #12;
        chk("rst_fwd",     {12'h0, fwd_sel}, 16'h0);
        chk("rst_stall",   {15'h0, stall},   16'h0);
        chk("rst_busy",    {15'h0, mc_busy}, 16'h0);
        chk("rst_done",    {15'h0, mc_done}, 16'h0);
        chk("rst_bubble",  {15'h0, ex_bubble}, 16'h1);
        chk("rst_cnt",     stall_cnt, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        //             v  s1 s0 srcv  fl erd emr mrd mwr wrd wwr  st fwd      bub
        vt[0]  = mk(1, 3, 3, 2'b11, 0, 0, 0,  3, 1,  3, 1,  0, 4'b1010, 0);
        vt[1]  = mk(1, 3, 3, 2'b11, 0, 0, 0,  3, 0,  3, 1,  0, 4'b0101, 0);
        vt[2]  = mk(1, 0, 0, 2'b11, 0, 0, 0,  3, 1,  3, 1,  0, 4'b0000, 0);
        vt[3]  = mk(1, 0, 0, 2'b11, 0, 0, 0,  0, 1,  0, 1,  0, 4'b0000, 0);
        vt[4]  = mk(1, 3, 4, 2'b11, 0, 0, 0,  4, 1,  3, 1,  0, 4'b0110, 0);
        vt[5]  = mk(1, 3, 3, 2'b01, 0, 0, 0,  3, 1,  3, 1,  0, 4'b0010, 0);
        vt[6]  = mk(0, 3, 3, 2'b11, 0, 0, 0,  3, 1,  3, 1,  0, 4'b0000, 1);
        vt[7]  = mk(1, 0, 5, 2'b11, 0, 5, 1,  5, 1,  5, 1,  1, 4'b0000, 1);
        vt[8]  = mk(1, 0, 5, 2'b11, 1, 5, 1,  5, 1,  5, 1,  0, 4'b0000, 1);
        vt[9]  = mk(1, 0, 0, 2'b11, 0, 0, 1,  0, 0,  0, 0,  0, 4'b0000, 0);
        vt[10] = mk(1, 5, 5, 2'b00, 0, 5, 1,  5, 1,  5, 1,  0, 4'b0000, 0);
        vt[11] = mk(0, 5, 5, 2'b11, 0, 5, 1,  0, 0,  0, 0,  0, 4'b0000, 1);
        vt[12] = mk(1, 5, 2, 2'b10, 0, 5, 1,  5, 1,  0, 0,  1, 4'b0000, 1);

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            idle();
            id_valid     = vt[k].id_valid;
            id_src       = vt[k].id_src;
            id_src_v     = vt[k].id_src_v;
            flush        = vt[k].flush;
            ex_rd        = vt[k].ex_rd;
            ex_memread   = vt[k].ex_memread;
            mem_rd       = vt[k].mem_rd;
            mem_regwrite = vt[k].mem_regwrite;
            wb_rd        = vt[k].wb_rd;
            wb_regwrite  = vt[k].wb_regwrite;
            exq.push_back('{fwd: vt[k].exp_fwd, bubble: vt[k].exp_bubble});
            #1;
            chk($sformatf("v%0d_stall", k), {15'h0, stall}, {15'h0, vt[k].exp_stall});
            @(posedge clk);
            #1;
            e = exq.pop_front();
            chk($sformatf("v%0d_fwd", k), {12'h0, fwd_sel}, {12'h0, e.fwd});
            chk($sformatf("v%0d_bubble", k), {15'h0, ex_bubble}, {15'h0, e.bubble});
        end

        // load-use: load r5 in EX, ID reads r5 on source 0
        do_reset();
        id_valid   = 1'b1;
        id_src     = {5'd0, 5'd5};
        id_src_v   = 2'b01;
        ex_rd      = 5'd5;
        ex_memread = 1'b1;
        #1;
        chk("lu_stall", {15'h0, stall}, 16'h1);
        @(negedge clk);
        chk("lu_bubble", {15'h0, ex_bubble}, 16'h1);
        ex_memread   = 1'b0;
        ex_rd        = '0;
        mem_rd       = 5'd5;
        mem_regwrite = 1'b1;
        #1;
        chk("lu_stall_off", {15'h0, stall}, 16'h0);
        chk("lu_fwd_bubble", {12'h0, fwd_sel}, 16'h0);
        @(negedge clk);
        mem_rd       = '0;
        mem_regwrite = 1'b0;
        wb_rd        = 5'd5;
        wb_regwrite  = 1'b1;
        #1;
        chk("lu_fwd_wb", {12'h0, fwd_sel}, 16'h1);
        chk("lu_dep_in_ex", {15'h0, ex_bubble}, 16'h0);

        // MC op to r7 followed by a dependent reader
        @(negedge clk);
        idle();
        issue_mc(5'd7);
        #1;
        chk("mc_issue_nostall", {15'h0, stall}, 16'h0);
        chk("mc_pre_busy", {15'h0, mc_busy}, 16'h0);
        @(negedge clk);
        id_is_mc = 1'b0;
        id_src   = {5'd0, 5'd7};
        id_src_v = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("mc_stall_c%0d", i), {15'h0, stall}, 16'h1);
            chk($sformatf("mc_busy_c%0d", i), {15'h0, mc_busy}, 16'h1);
            chk($sformatf("mc_done_c%0d", i), {15'h0, mc_done}, (i == 3) ? 16'h1 : 16'h0);
            @(negedge clk);
        end
        #1;
        chk("mc_after_stall", {15'h0, stall}, 16'h0);
        chk("mc_after_busy", {15'h0, mc_busy}, 16'h0);
        chk("mc_after_done", {15'h0, mc_done}, 16'h0);

`ifdef HFS_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, 16'd5);
`else
        chk("stall_cnt", stall_cnt, 16'd0);
`endif

        // independent instruction (r8) proceeds while the MC op is in flight
        @(negedge clk);
        idle();
        issue_mc(5'd7);
        @(negedge clk);
        id_is_mc = 1'b0;
        id_src   = {5'd0, 5'd8};
        id_src_v = 2'b01;
        #1;
        chk("indep_nostall", {15'h0, stall}, 16'h0);
        chk("indep_busy", {15'h0, mc_busy}, 16'h1);
        @(negedge clk);
        idle();
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (!mc_busy) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("indep_drain", {15'h0, seen}, 16'h1);

        // second MC op while busy: stalled until RUN, then issues
        @(negedge clk);
        idle();
        issue_mc(5'd9);
        @(negedge clk);
        issue_mc(5'd10);
        nst = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (!stall) break;
            nst++;
            @(negedge clk);
        end
        chk("mc2_stall_cycles", 16'(nst), 16'd4);
        chk("mc2_run_busy", {15'h0, mc_busy}, 16'h0);
        @(posedge clk);
        #1;
        chk("mc2_reissue_busy", {15'h0, mc_busy}, 16'h1);
        @(negedge clk);
        idle();
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (!mc_busy) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("mc2_drain", {15'h0, seen}, 16'h1);

        // flush does not cancel an MC op; async reset does
        @(negedge clk);
        idle();
        issue_mc(5'd7);
        @(negedge clk);
        id_is_mc     = 1'b0;
        id_src       = {5'd7, 5'd7};
        id_src_v     = 2'b11;
        flush        = 1'b1;
        mem_rd       = 5'd7;
        mem_regwrite = 1'b1;
        #1;
        chk("flush_mc_nostall", {15'h0, stall}, 16'h0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_keeps_busy", {15'h0, mc_busy}, 16'h1);
        chk("pre_rst_stall", {15'h0, stall}, 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {15'h0, mc_busy}, 16'h0);
        chk("arst_stall", {15'h0, stall}, 16'h0);
        chk("arst_done", {15'h0, mc_done}, 16'h0);
        chk("arst_fwd", {12'h0, fwd_sel}, 16'h0);
        chk("arst_bubble", {15'h0, ex_bubble}, 16'h1);
        chk("arst_cnt", stall_cnt, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
